// File: rtl/reg_enc_pkg.sv
// ---------------------------------------------------------------------------
// reg_enc_pkg
// Shared types and constants for the register write-enable encoder.
//   enc_state_t : encoder state (IDLE / BUSY)
//   REG_CNT     : number of registers (width of the enable vector)
//   REG_IDX_W   : width of a register number, clog2(REG_CNT)
//   popcount()  : number of set bits in an enable vector. It is used only
//                 by the optional multi-bit check (ENC_MULTI_CHK_EN).
// ---------------------------------------------------------------------------
package reg_enc_pkg;

    localparam int REG_CNT   = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } enc_state_t;

    function automatic logic [REG_IDX_W:0] popcount(input logic [REG_CNT-1:0] vec);
        logic [REG_IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            cnt = cnt + (REG_IDX_W+1)'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_enc32x5.sv
// ---------------------------------------------------------------------------
// prio_enc32x5
// Purely combinational encoder that finds the lowest set bit of a 32-bit vector.
//   vec : input vector
//   idx : index of the lowest set bit (0 when vec is zero)
//   any : high when at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_enc32x5
    import reg_enc_pkg::*;
(
    input  logic [REG_CNT-1:0]   vec,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 any
);

    // The loop scans from the top bit down. A later (lower) hit overwrites an
    // earlier one, so the lowest set index wins.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = REG_CNT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = REG_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_enable_encoder.sv
// ---------------------------------------------------------------------------
// reg_enable_encoder
// Serializing encoder for register write-enable vectors. A loaded vector is
// drained one register number at a time, lowest index first. Each index is
// passed over a valid/ready handshake.
//
// Ports
//   clk      : sole clock, rising edge
//   rst_n    : synchronous active-low reset
//   E_in     : enable vector, sampled only when a load is accepted
//   Ld       : load request, accepted only while ld_ready is high
//   ld_ready : encoder is idle and can accept a load
//   C        : register number of the lowest pending bit (0 when not valid)
//   C_valid  : C is valid (encoder busy)
//   C_ready  : consumer accepts C
//   done     : one-cycle pulse after a loaded vector has fully drained,
//              including an all-zero load
//   multi    : (only with ENC_MULTI_CHK_EN) one-cycle pulse after a load
//              whose vector has more than one bit set
//
// Configuration macro: ENC_MULTI_CHK_EN adds the multi port and its popcount.
// OpCode_bits must equal clog2(DATA_WIDTH). The encoder core is fixed at 32/5.
// ---------------------------------------------------------------------------
module reg_enable_encoder
    import reg_enc_pkg::*;
#(
    parameter int DATA_WIDTH  = REG_CNT,
    parameter int OpCode_bits = REG_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  E_in,
    input  logic                   Ld,
    output logic                   ld_ready,
    output logic [OpCode_bits-1:0] C,
    output logic                   C_valid,
    input  logic                   C_ready,
`ifdef ENC_MULTI_CHK_EN
    output logic                   multi,
`endif
    output logic                   done
);

    enc_state_t              state_q, state_d;
    logic [DATA_WIDTH-1:0]   pending_q, pending_d;
    logic                    done_q, done_d;
    logic [OpCode_bits-1:0]  enc_idx;
    logic                    enc_any;
    logic [DATA_WIDTH-1:0]   pending_clr;

    prio_enc32x5 u_prio (
        .vec (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // pending with the currently presented bit (enc_idx) removed.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_clr
        assign pending_clr[gi] = pending_q[gi] && (enc_idx != OpCode_bits'(gi));
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Ld) begin
                    if (E_in != '0) begin
                        pending_d = E_in;
                        state_d   = BUSY;
                    end else begin
                        // An empty vector finishes immediately and emits no index.
                        done_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (C_ready) begin
                    pending_d = pending_clr;
                    if (pending_clr == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

`ifdef ENC_MULTI_CHK_EN
    logic multi_q, multi_d;

    always_comb begin
        multi_d = (state_q == IDLE) && Ld && (popcount(E_in) > (REG_IDX_W+1)'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign multi = multi_q;
`endif

    assign ld_ready = (state_q == IDLE);
    assign C_valid  = (state_q == BUSY);
    assign C        = (C_valid && enc_any) ? enc_idx : '0;
    assign done     = done_q;

endmodule

// File: tb/tb_reg_enable_encoder.sv
module tb_reg_enable_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] E_in;
    logic        Ld;
    logic        ld_ready;
    logic [4:0]  C;
    logic        C_valid;
    logic        C_ready;
    logic        done;
`ifdef ENC_MULTI_CHK_EN
    logic        multi;
`endif

    always #5 clk = ~clk;

    reg_enable_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .E_in     (E_in),
        .Ld       (Ld),
        .ld_ready (ld_ready),
        .C        (C),
        .C_valid  (C_valid),
        .C_ready  (C_ready),
`ifdef ENC_MULTI_CHK_EN
        .multi    (multi),
`endif
        .done     (done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model. The queue holds the register numbers still to be
    // emitted, lowest first. An empty queue means the encoder is idle.
    int q[$];
    bit m_done;
    bit m_multi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic l, input logic [31:0] e, input logic cr);
        int ones;
        if (!r) begin
            q.delete();
            m_done  = 1'b0;
            m_multi = 1'b0;
        end else begin
            m_done  = 1'b0;
            m_multi = 1'b0;
            if (q.size() == 0) begin
                if (l) begin
                    ones = 0;
                    for (int i = 0; i < 32; i++) begin
                        if (e[i]) begin
                            q.push_back(i);
                            ones++;
                        end
                    end
                    if (ones == 0) m_done = 1'b1;
                    m_multi = (ones > 1);
                end
            end else if (cr) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end
    endtask

    // One clock: drive the inputs and take the edge. Then update the model and
    // compare every output 1 time unit after the edge.
    task automatic cyc(input string tag, input logic r, input logic l,
                       input logic [31:0] e, input logic cr);
        logic [31:0] exp_c;
        rst_n   = r;
        Ld      = l;
        E_in    = e;
        C_ready = cr;
        @(posedge clk);
        model_edge(r, l, e, cr);
        #1;
        exp_c = (q.size() != 0) ? 32'(q[0]) : 32'd0;
        chk({tag, ".ld_ready"}, {31'd0, ld_ready}, {31'd0, q.size() == 0});
        chk({tag, ".C_valid"},  {31'd0, C_valid},  {31'd0, q.size() != 0});
        chk({tag, ".C"},        {27'd0, C},        exp_c);
        chk({tag, ".done"},     {31'd0, done},     {31'd0, m_done});
`ifdef ENC_MULTI_CHK_EN
        chk({tag, ".multi"},    {31'd0, multi},    {31'd0, m_multi});
`endif
        $display("%-10s rst_n=%b Ld=%b E_in=%08h C_ready=%b -> ld_ready=%b C_valid=%b C=%0d done=%b",
                 tag, r, l, e, cr, ld_ready, C_valid, C, done);
    endtask

    // Idle cycles with C_ready high until the model reports idle (bounded).
    task automatic drain(input string tag);
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            cyc(tag, 1'b1, 1'b0, 32'h0, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] rv;
        rst_n = 1'b0; Ld = 1'b0; E_in = '0; C_ready = 1'b0;

        // Reset
        cyc("reset", 1'b0, 1'b0, 32'h0, 1'b0);
        cyc("reset", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cyc("idle",  1'b1, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of draining 0x0F00
        cyc("rst_mid", 1'b1, 1'b1, 32'h0000_0F00, 1'b1);
        cyc("rst_mid", 1'b1, 1'b0, 32'h0, 1'b1);
        cyc("rst_mid", 1'b0, 1'b0, 32'h0, 1'b1);
        cyc("rst_mid", 1'b1, 1'b0, 32'h0, 1'b1);
        cyc("rst_mid", 1'b1, 1'b0, 32'h0, 1'b1);

        // One-hot vector
        cyc("onehot", 1'b1, 1'b1, 32'h0000_0400, 1'b1);
        drain("onehot");
        cyc("onehot", 1'b1, 1'b0, 32'h0, 1'b1);

        // Several set bits with a 3-cycle stall
        cyc("stall", 1'b1, 1'b1, 32'h8000_0011, 1'b0);
        for (int k = 0; k < 3; k++) cyc("stall", 1'b1, 1'b0, 32'h0, 1'b0);
        drain("stall");
        cyc("stall", 1'b1, 1'b0, 32'h0, 1'b0);

        // Zero vector
        cyc("zero", 1'b1, 1'b1, 32'h0, 1'b1);
        cyc("zero", 1'b1, 1'b0, 32'h0, 1'b1);

        // Load while busy is ignored
        cyc("ldbusy", 1'b1, 1'b1, 32'h0000_0003, 1'b0);
        cyc("ldbusy", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cyc("ldbusy", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cyc("ldbusy", 1'b1, 1'b0, 32'h0, 1'b1);

        // Back-to-back: load in the done cycle of the previous vector
        cyc("b2b", 1'b1, 1'b1, 32'h0000_0001, 1'b1);
        cyc("b2b", 1'b1, 1'b0, 32'h0, 1'b1);
        cyc("b2b", 1'b1, 1'b1, 32'h0000_0002, 1'b1);
        drain("b2b");

        // Single-bit and two-bit vectors for the multi-bit flag
        cyc("multi", 1'b1, 1'b1, 32'h0000_0006, 1'b1);
        drain("multi");
        cyc("multi", 1'b1, 1'b1, 32'h0000_0004, 1'b1);
        drain("multi");
        cyc("multi", 1'b1, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0:       rv = 32'h0;
                1:       rv = 32'h1 << $urandom_range(0, 31);
                2:       rv = $urandom;
                default: rv = $urandom & $urandom & $urandom;
            endcase
            cyc("rand", ($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0),
                rv, ($urandom_range(0, 3) != 0));
        end
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
